ect_scan_sequencer: RTL
=======================

Name: ect_scan_sequencer

Overview:
- Sequences one ECT measurement frame: steps all excitation/detection electrode pairs, drives the analog switch selects, waits a settling time, runs the demodulator once per pair, and hands each result downstream with its pair index.
- Sits between the command controller (Start/Stop/Continuous) and the demodulator. Output goes to the frame FIFO / UART packer through a valid/ready handshake.
- For N electrodes, a frame is N(N-1)/2 measurements (66 for N=12).

Parameters:
- NELEC, 12, number of electrodes; legal range 3..16.
- SETTLE_CYC, 2000, Clk cycles between switch change and DemodEn assertion; minimum 1.
- DEMOD_TO, 65535, maximum Clk cycles to wait for DemodReady before declaring a timeout.

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse; begin a frame
- Stop  in  1  one-cycle pulse; abort or end scanning
- Continuous  in  1  level; 1 = restart a new frame automatically after each FrameDone
- ExcSel  out  4  excitation electrode select
- DetSel  out  4  detection electrode select
- MuxEn  out  1  analog switch enable
- DemodEn  out  1  demodulator run request (level)
- DemodReady  in  1  demodulator result valid (level)
- DemodResult  in  32  demodulator magnitude
- MeasValid  out  1  downstream data valid
- MeasReady  in  1  downstream accept
- MeasData  out  32  measurement value
- MeasIdx  out  7  pair index within the frame, 0..N(N-1)/2-1
- FrameDone  out  1  one-cycle pulse after the last measurement of a frame is accepted
- Busy  out  1  high in every state except IDLE
- TimeoutErr  out  1  sticky demodulator timeout flag
- FrameCnt  out  16  completed frames; wraps at 65535 -> 0

Behaviour:
- Reset: all outputs are 0 and the state is IDLE.
- Pair order: exc = 0..N-2; for each exc, det = exc+1..N-1. MeasIdx starts at 0 and increments by 1 per pair.
- State IDLE:
  - On Start (and Stop low): clear TimeoutErr, load exc=0, det=1, idx=0, then go to SETUP.
  - Start and Stop in the same cycle: Stop wins; remain in IDLE.
- State SETUP (1 cycle): drive ExcSel/DetSel, set MuxEn=1, load the settle counter, then go to SETTLE.
- State SETTLE:
  - Count SETTLE_CYC cycles.
  - Then assert DemodEn, load the timeout counter, and go to DEMOD.
- State DEMOD:
  - Hold DemodEn=1 until DemodReady is sampled 1.
  - On DemodReady: latch DemodResult into MeasData, drop DemodEn, set MeasValid=1, go to OUTPUT.
  - If DEMOD_TO cycles elapse first: set TimeoutErr, MeasData=32'hFFFFFFFF, drop DemodEn, set MeasValid=1, go to OUTPUT. The frame always contains every index.
- State OUTPUT:
  - MeasValid, MeasData and MeasIdx stay stable until MeasValid&MeasReady.
  - On that cycle drop MeasValid and go to NEXT.
- State NEXT (1 cycle):
  - Not the last pair: advance det; on det==N-1, advance exc and set det=exc+1. Increment idx and go to SETUP.
  - Last pair (N-2,N-1): pulse FrameDone, increment FrameCnt. If Continuous=1 and no Stop is pending, reload (0,1) with idx=0 and go to SETUP; otherwise drop MuxEn and go to IDLE.
- Stop handling:
  - In SETUP, SETTLE or DEMOD: abort on the next cycle. DemodEn=0, MuxEn=0, MeasValid=0, return to IDLE. No FrameDone pulse, FrameCnt unchanged.
  - In OUTPUT or NEXT: latch a pending-stop flag, complete the current handshake, then go to IDLE. FrameDone still fires if the current pair was the last pair.
- Start while Busy: ignored.
- Continuous sampling: sampled only in NEXT on the last pair.
- DemodReady outside DEMOD: ignored.
- Minimum latency, Start to first DemodEn: 1 (IDLE->SETUP) + 1 (SETUP) + SETTLE_CYC cycles.
- Reset mid-frame: immediate return to reset values, including FrameCnt.

Test Plan:
- NELEC=4, SETTLE_CYC=4, MeasReady=1, demod returns Ready 3 cycles after DemodEn with result 0x100+idx -> 6 outputs with (Exc,Det) = (0,1)(0,2)(0,3)(1,2)(1,3)(2,3), MeasIdx 0..5, data 0x100..0x105. One FrameDone, FrameCnt=1, Busy low afterwards.
- Same configuration: DemodEn rises exactly 6 cycles after the Start pulse; MuxEn is high 4 cycles before DemodEn.
- MeasReady held low 10 cycles on idx 2 -> MeasValid/MeasData/MeasIdx stable for all 10 cycles, no new DemodEn during the stall, and the frame completes correctly.
- DEMOD_TO=20, DemodReady never asserted on idx 1 -> TimeoutErr=1, MeasData=0xFFFFFFFF for idx 1. The frame continues; TimeoutErr clears on the next Start.
- Stop pulsed during SETTLE of idx 3 -> MuxEn and DemodEn at 0 the next cycle, Busy=0, no FrameDone, FrameCnt unchanged. A following Start restarts at idx 0 with (0,1).
- Continuous=1 for 3 frames, then Stop pulsed during OUTPUT of idx 5 of frame 3 -> that handshake completes, FrameDone fires, FrameCnt=3, return to IDLE. Start+Stop in the same IDLE cycle -> remains IDLE.

Source files
------------

// File: rtl/ect_scan_sequencer_if.sv
// Demodulator request/result and measurement output handshake bundle for the
// ECT scan sequencer. The master side is the sequencer; the slave side is the
// demodulator plus the downstream frame FIFO / packer.
interface ect_scan_sequencer_if;
  logic        DemodEn;
  logic        DemodReady;
  logic [31:0] DemodResult;
  logic        MeasValid;
  logic        MeasReady;
  logic [31:0] MeasData;
  logic [6:0]  MeasIdx;

  modport master (
    output DemodEn,
    input  DemodReady,
    input  DemodResult,
    output MeasValid,
    input  MeasReady,
    output MeasData,
    output MeasIdx
  );

  modport slave (
    input  DemodEn,
    output DemodReady,
    output DemodResult,
    input  MeasValid,
    output MeasReady,
    input  MeasData,
    input  MeasIdx
  );
endinterface

// File: rtl/ect_scan_sequencer.sv
// ECT scan sequencer: walks every excitation/detection electrode pair of one
// frame, drives the analog switch selects, waits for the electrodes to settle,
// runs the demodulator once per pair and hands each result downstream with its
// pair index. A demodulator that never answers yields an all-ones sample so a
// frame always carries every index.
module ect_scan_sequencer #(
  parameter int NELEC      = 12,
  parameter int SETTLE_CYC = 2000,
  parameter int DEMOD_TO   = 65535
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Continuous,
  output logic [3:0]             ExcSel,
  output logic [3:0]             DetSel,
  output logic                   MuxEn,
  ect_scan_sequencer_if.master   bus,
  output logic                   FrameDone,
  output logic                   Busy,
  output logic                   TimeoutErr,
  output logic [15:0]            FrameCnt
);

  // One down-counter serves both the settle wait and the demod timeout,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (SETTLE_CYC > DEMOD_TO) ? SETTLE_CYC : DEMOD_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(DEMOD_TO - 1);
  localparam logic [3:0]       EXC_LAST    = 4'(NELEC - 2);
  localparam logic [3:0]       DET_LAST    = 4'(NELEC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SETTLE,
    DEMOD,
    OUTPUT,
    NEXT
  } state_t;

  state_t           state;
  logic [3:0]       exc;
  logic [3:0]       det;
  logic [6:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             stopPend;
  logic             lastPair;
  logic             inRun;

  assign lastPair    = (exc == EXC_LAST) && (det == DET_LAST);
  // Stop aborts immediately only while no result is being handed off.
  assign inRun       = (state == SETUP) || (state == SETTLE) || (state == DEMOD);
  assign bus.MeasIdx = idx;

  // Frame sequencing FSM with all outputs registered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state         <= IDLE;
      exc           <= 4'd0;
      det           <= 4'd0;
      idx           <= 7'd0;
      cnt           <= '0;
      stopPend      <= 1'b0;
      ExcSel        <= 4'd0;
      DetSel        <= 4'd0;
      MuxEn         <= 1'b0;
      bus.DemodEn   <= 1'b0;
      bus.MeasValid <= 1'b0;
      bus.MeasData  <= 32'd0;
      FrameDone     <= 1'b0;
      Busy          <= 1'b0;
      TimeoutErr    <= 1'b0;
      FrameCnt      <= 16'd0;
    end else begin
      FrameDone <= 1'b0;

      if (Stop && inRun) begin
        // Abort: release the switches and the demodulator, no frame credit.
        bus.DemodEn   <= 1'b0;
        bus.MeasValid <= 1'b0;
        MuxEn         <= 1'b0;
        Busy          <= 1'b0;
        stopPend      <= 1'b0;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            stopPend <= 1'b0;
            // Stop has priority over a coincident Start.
            if (Start && !Stop) begin
              TimeoutErr <= 1'b0;
              exc        <= 4'd0;
              det        <= 4'd1;
              idx        <= 7'd0;
              Busy       <= 1'b1;
              state      <= SETUP;
            end
          end

          SETUP: begin
            ExcSel <= exc;
            DetSel <= det;
            MuxEn  <= 1'b1;
            cnt    <= SETTLE_LOAD;
            state  <= SETTLE;
          end

          SETTLE: begin
            if (cnt == '0) begin
              bus.DemodEn <= 1'b1;
              cnt         <= TO_LOAD;
              state       <= DEMOD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end

          DEMOD: begin
            if (bus.DemodReady) begin
              bus.MeasData  <= bus.DemodResult;
              bus.DemodEn   <= 1'b0;
              bus.MeasValid <= 1'b1;
              state         <= OUTPUT;
            end else if (cnt == '0) begin
              // Substitute a marker sample so the frame keeps every index.
              TimeoutErr    <= 1'b1;
              bus.MeasData  <= 32'hFFFF_FFFF;
              bus.DemodEn   <= 1'b0;
              bus.MeasValid <= 1'b1;
              state         <= OUTPUT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end

          OUTPUT: begin
            // A stop here is deferred until the handshake has finished.
            if (Stop) begin
              stopPend <= 1'b1;
            end
            if (bus.MeasReady) begin
              bus.MeasValid <= 1'b0;
              state         <= NEXT;
            end
          end

          NEXT: begin
            if (lastPair) begin
              FrameDone <= 1'b1;
              FrameCnt  <= FrameCnt + 16'd1;
            end
            if (lastPair && Continuous && !stopPend && !Stop) begin
              exc   <= 4'd0;
              det   <= 4'd1;
              idx   <= 7'd0;
              state <= SETUP;
            end else if (!lastPair && !stopPend && !Stop) begin
              if (det == DET_LAST) begin
                exc <= exc + 4'd1;
                det <= exc + 4'd2;
              end else begin
                det <= det + 4'd1;
              end
              idx   <= idx + 7'd1;
              state <= SETUP;
            end else begin
              MuxEn    <= 1'b0;
              Busy     <= 1'b0;
              stopPend <= 1'b0;
              state    <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
